matrix_slot_arbiter: RTL and testbench

//  Sits between the matrix write sources (UART RX handler, compute-result writer) and matrix storage.

---
 rtl/matrix_slot_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_matrix_slot_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_arbiter.sv
// Round-robin write arbiter between the RX and compute matrix sources; allocates a
// per-dimension storage slot (oldest overwritten) and tracks valid-slot counts.
module matrix_slot_arbiter #(
   parameter int unsigned MAX_DIM = 5,
   parameter int unsigned SLOTS   = 2,
   parameter int unsigned IDX_W   = 3   // 2**IDX_W must exceed SLOTS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_req,
   input  logic [2:0]       rx_row,
   input  logic [2:0]       rx_col,
   input  logic             cmp_req,
   input  logic [2:0]       cmp_row,
   input  logic [2:0]       cmp_col,
   input  logic             clear_all,
   input  logic [2:0]       q_row,
   input  logic [2:0]       q_col,
   output logic [IDX_W-1:0] q_count,
   output logic             wr_en,
   output logic             wr_sel,
   output logic [2:0]       wr_row,
   output logic [2:0]       wr_col,
   output logic [IDX_W-1:0] wr_idx,
   output logic             done,
   output logic             done_src,
   output logic             done_err,
   output logic [1:0]       ovf,
   output logic             busy
);

   localparam int unsigned NUM_DIMS = MAX_DIM * MAX_DIM;
   localparam int unsigned D_W      = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;
   localparam logic [2:0]       MAX_DIM_V = 3'(MAX_DIM);
   localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(SLOTS - 1);
   localparam logic [IDX_W-1:0] FULL_CNT  = IDX_W'(SLOTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic             rx_pend, cmp_pend;
   logic [2:0]       rx_pend_row, rx_pend_col;
   logic [2:0]       cmp_pend_row, cmp_pend_col;
   logic             rr_cmp;
   logic             grant_rx, grant_cmp, contend;
   logic             wr_ok;
   logic [D_W-1:0]   wr_d;
   logic             enter_write, enter_done;

   logic [IDX_W-1:0] ptr_q [NUM_DIMS];
   logic [IDX_W-1:0] cnt_q [NUM_DIMS];

   function automatic logic dims_valid(input logic [2:0] r, input logic [2:0] c);
      return (r != 3'd0) && (r <= MAX_DIM_V) && (c != 3'd0) && (c <= MAX_DIM_V);
   endfunction

   // Row-major flat index; only meaningful when dims_valid holds.
   function automatic logic [D_W-1:0] dim_index(input logic [2:0] r, input logic [2:0] c);
      int unsigned v;
      v = (32'(r) - 32'd1) * MAX_DIM + (32'(c) - 32'd1);
      return D_W'(v);
   endfunction

   assign wr_ok       = dims_valid(wr_row, wr_col);
   assign wr_d        = dim_index(wr_row, wr_col);
   assign enter_write = (state == S_GRANT) && wr_ok;
   assign enter_done  = (state == S_WRITE) || ((state == S_GRANT) && !wr_ok);

   always_comb begin
      if (dims_valid(q_row, q_col)) q_count = cnt_q[dim_index(q_row, q_col)];
      else                          q_count = '0;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and grant decision; contention alternates via rr_cmp.
   always_comb begin
      state_nxt = state;
      grant_rx  = 1'b0;
      grant_cmp = 1'b0;
      contend   = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_pend && cmp_pend) begin
               contend   = 1'b1;
               grant_cmp = rr_cmp;
               grant_rx  = !rr_cmp;
               state_nxt = S_GRANT;
            end else if (rx_pend) begin
               grant_rx  = 1'b1;
               state_nxt = S_GRANT;
            end else if (cmp_pend) begin
               grant_cmp = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: state_nxt = wr_ok ? S_WRITE : S_DONE;
         S_WRITE: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Per-source pending capture; a fresh request always wins over the grant clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_pend      <= 1'b0;
         rx_pend_row  <= '0;
         rx_pend_col  <= '0;
         cmp_pend     <= 1'b0;
         cmp_pend_row <= '0;
         cmp_pend_col <= '0;
         ovf          <= '0;
      end else begin
         ovf <= {cmp_req && cmp_pend && !grant_cmp, rx_req && rx_pend && !grant_rx};
         if (rx_req) begin
            rx_pend     <= 1'b1;
            rx_pend_row <= rx_row;
            rx_pend_col <= rx_col;
         end else if (grant_rx) begin
            rx_pend <= 1'b0;
         end
         if (cmp_req) begin
            cmp_pend     <= 1'b1;
            cmp_pend_row <= cmp_row;
            cmp_pend_col <= cmp_col;
         end else if (grant_cmp) begin
            cmp_pend <= 1'b0;
         end
      end
   end

   // Registered storage-side outputs and arbitration history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en    <= 1'b0;
         wr_sel   <= 1'b0;
         wr_row   <= '0;
         wr_col   <= '0;
         wr_idx   <= '0;
         done     <= 1'b0;
         done_src <= 1'b0;
         done_err <= 1'b0;
         busy     <= 1'b0;
         rr_cmp   <= 1'b0;
      end else begin
         wr_en    <= enter_write;
         done     <= enter_done;
         done_err <= (state == S_GRANT) && !wr_ok;
         done_src <= enter_done ? wr_sel : 1'b0;
         busy     <= (state_nxt != S_IDLE);
         if (grant_rx || grant_cmp) begin
            wr_sel <= grant_cmp;
            wr_row <= grant_cmp ? cmp_pend_row : rx_pend_row;
            wr_col <= grant_cmp ? cmp_pend_col : rx_pend_col;
         end
         if (enter_write) wr_idx <= ptr_q[wr_d];
         if (contend)     rr_cmp <= grant_rx;
      end
   end

   // Slot pointers and valid counts; clear_all overrides a coincident write update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_DIMS; i++) begin
            ptr_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (clear_all) begin
         for (int unsigned i = 0; i < NUM_DIMS; i++) begin
            ptr_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (state == S_WRITE) begin
         ptr_q[wr_d] <= (ptr_q[wr_d] == LAST_SLOT) ? '0 : ptr_q[wr_d] + IDX_W'(1);
         cnt_q[wr_d] <= (cnt_q[wr_d] == FULL_CNT) ? FULL_CNT : cnt_q[wr_d] + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_matrix_slot_arbiter.sv
// Directed bench for matrix_slot_arbiter: latency, slot rotation, round-robin,
// invalid dims, overflow, clear_all and mid-operation reset.
module tb_matrix_slot_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_req, cmp_req, clear_all;
   logic [2:0] rx_row, rx_col, cmp_row, cmp_col, q_row, q_col;
   logic [2:0] q_count, wr_row, wr_col, wr_idx;
   logic       wr_en, wr_sel, done, done_src, done_err, busy;
   logic [1:0] ovf;

   matrix_slot_arbiter #(.MAX_DIM(5), .SLOTS(2), .IDX_W(3)) dut (
      .clk(clk), .rst(rst),
      .rx_req(rx_req), .rx_row(rx_row), .rx_col(rx_col),
      .cmp_req(cmp_req), .cmp_row(cmp_row), .cmp_col(cmp_col),
      .clear_all(clear_all), .q_row(q_row), .q_col(q_col), .q_count(q_count),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_idx(wr_idx),
      .done(done), .done_src(done_src), .done_err(done_err), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [2:0] row;
      logic [2:0] col;
      logic [2:0] idx;
      logic       sel;
   } wr_rec_t;

   typedef struct {
      int   cyc;
      logic src;
      logic err;
   } done_rec_t;

   int        cyc = 0;
   int        cmps = 0;
   int        errs = 0;
   wr_rec_t   wr_q[$];
   done_rec_t done_q[$];
   int        ovf_rx_n, ovf_cmp_n, ovf_rx_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled mid-cycle.
   always @(negedge clk) begin
      wr_rec_t   w;
      done_rec_t d;
      if (wr_en === 1'b1) begin
         w.cyc = cyc; w.row = wr_row; w.col = wr_col; w.idx = wr_idx; w.sel = wr_sel;
         wr_q.push_back(w);
      end
      if (done === 1'b1) begin
         d.cyc = cyc; d.src = done_src; d.err = done_err;
         done_q.push_back(d);
      end
      if (ovf[0] === 1'b1) begin ovf_rx_n++; ovf_rx_cyc = cyc; end
      if (ovf[1] === 1'b1) ovf_cmp_n++;
   end

   task automatic clear_log();
      wr_q.delete();
      done_q.delete();
      ovf_rx_n = 0; ovf_cmp_n = 0; ovf_rx_cyc = -1;
   endtask

   // One clock cycle worth of inputs, applied just after the rising edge.
   task automatic drive(input logic rxr, input logic [2:0] rr, input logic [2:0] rc,
                        input logic cmr, input logic [2:0] cr, input logic [2:0] cc,
                        input logic clr);
      @(posedge clk); #1;
      rx_req = rxr; rx_row = rr; rx_col = rc;
      cmp_req = cmr; cmp_row = cr; cmp_col = cc;
      clear_all = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      rx_req = 1'b0; cmp_req = 1'b0; clear_all = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_log();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_req = 1'b0; cmp_req = 1'b0; clear_all = 1'b0;
      rx_row = 3'd0; rx_col = 3'd0; cmp_row = 3'd0; cmp_col = 3'd0;
      q_row = 3'd2; q_col = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      if ({wr_en, wr_sel, wr_row, wr_col, wr_idx, done, done_src, done_err, ovf, busy} !== 17'd0) begin
         $display("FAIL reset_outputs: got %b want all zero",
                  {wr_en, wr_sel, wr_row, wr_col, wr_idx, done, done_src, done_err, ovf, busy});
         errs++;
      end
      cmps++;
      if (q_count !== 3'd0) begin $display("FAIL reset_q_count: got %0d want 0", q_count); errs++; end
      cmps++;
      rst = 1'b0;
      clear_log();
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      drive(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);
      c0 = cyc;
      idle(8);
      if (wr_q.size() !== 1) begin $display("FAIL single_wr_count: got %0d want 1", wr_q.size()); errs++; end
      cmps++;
      if (wr_q.size() > 0) begin
         if (wr_q[0].cyc !== c0 + 3) begin $display("FAIL single_wr_cycle: got %0d want %0d", wr_q[0].cyc - c0, 3); errs++; end
         cmps++;
         if ({wr_q[0].row, wr_q[0].col, wr_q[0].idx, wr_q[0].sel} !== {3'd2, 3'd3, 3'd0, 1'b0}) begin
            $display("FAIL single_wr_fields: got r%0d c%0d i%0d s%0d want r2 c3 i0 s0",
                     wr_q[0].row, wr_q[0].col, wr_q[0].idx, wr_q[0].sel);
            errs++;
         end
         cmps++;
      end
      if (done_q.size() !== 1) begin $display("FAIL single_done_count: got %0d want 1", done_q.size()); errs++; end
      cmps++;
      if (done_q.size() > 0) begin
         if (done_q[0].cyc !== c0 + 4 || done_q[0].src !== 1'b0 || done_q[0].err !== 1'b0) begin
            $display("FAIL single_done: got cyc+%0d src%0d err%0d want cyc+4 src0 err0",
                     done_q[0].cyc - c0, done_q[0].src, done_q[0].err);
            errs++;
         end
         cmps++;
      end
      q_row = 3'd2; q_col = 3'd3; #1;
      if (q_count !== 3'd1) begin $display("FAIL single_q_count: got %0d want 1", q_count); errs++; end
      cmps++;
   endtask

   task automatic test_slot_rotation();
      logic [2:0] exp_idx [3];
      logic [2:0] exp_cnt [3];
      exp_idx = '{3'd0, 3'd1, 3'd0};
      exp_cnt = '{3'd1, 3'd2, 3'd2};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);
         idle(7);
         if (wr_q.size() !== k + 1) begin
            $display("FAIL rot_wr_count[%0d]: got %0d want %0d", k, wr_q.size(), k + 1); errs++;
         end else if (wr_q[k].idx !== exp_idx[k]) begin
            $display("FAIL rot_wr_idx[%0d]: got %0d want %0d", k, wr_q[k].idx, exp_idx[k]); errs++;
         end
         cmps++;
         q_row = 3'd2; q_col = 3'd3; #1;
         if (q_count !== exp_cnt[k]) begin
            $display("FAIL rot_q_count[%0d]: got %0d want %0d", k, q_count, exp_cnt[k]); errs++;
         end
         cmps++;
      end
   endtask

   task automatic test_round_robin();
      int c0;
      do_reset();
      drive(1'b1, 3'd3, 3'd3, 1'b1, 3'd1, 3'd1, 1'b0);
      c0 = cyc;
      idle(12);
      if (wr_q.size() !== 2) begin $display("FAIL rr1_wr_count: got %0d want 2", wr_q.size()); errs++; end
      cmps++;
      if (wr_q.size() == 2) begin
         if ({wr_q[0].sel, wr_q[0].row, wr_q[0].col, wr_q[1].sel, wr_q[1].row, wr_q[1].col}
             !== {1'b0, 3'd3, 3'd3, 1'b1, 3'd1, 3'd1}) begin
            $display("FAIL rr1_order: got sel%0d %0dx%0d then sel%0d %0dx%0d want sel0 3x3 then sel1 1x1",
                     wr_q[0].sel, wr_q[0].row, wr_q[0].col, wr_q[1].sel, wr_q[1].row, wr_q[1].col);
            errs++;
         end
         cmps++;
         if (wr_q[1].cyc !== c0 + 7) begin $display("FAIL rr1_b2b_cycle: got %0d want 7", wr_q[1].cyc - c0); errs++; end
         cmps++;
      end
      if (done_q.size() !== 2 || done_q[0].src !== 1'b0 || done_q[1].src !== 1'b1) begin
         $display("FAIL rr1_done_src: got n%0d want n2 src 0 then 1", done_q.size()); errs++;
      end
      cmps++;
      clear_log();
      drive(1'b1, 3'd3, 3'd3, 1'b1, 3'd1, 3'd1, 1'b0);
      idle(12);
      if (wr_q.size() !== 2) begin $display("FAIL rr2_wr_count: got %0d want 2", wr_q.size()); errs++; end
      else if ({wr_q[0].sel, wr_q[0].row, wr_q[0].idx, wr_q[1].sel, wr_q[1].row, wr_q[1].idx}
               !== {1'b1, 3'd1, 3'd1, 1'b0, 3'd3, 3'd1}) begin
         $display("FAIL rr2_order: got sel%0d r%0d i%0d then sel%0d r%0d i%0d want sel1 r1 i1 then sel0 r3 i1",
                  wr_q[0].sel, wr_q[0].row, wr_q[0].idx, wr_q[1].sel, wr_q[1].row, wr_q[1].idx);
         errs++;
      end
      cmps++;
      q_row = 3'd3; q_col = 3'd3; #1;
      if (q_count !== 3'd2) begin $display("FAIL rr_q33: got %0d want 2", q_count); errs++; end
      cmps++;
      q_row = 3'd1; q_col = 3'd1; #1;
      if (q_count !== 3'd2) begin $display("FAIL rr_q11: got %0d want 2", q_count); errs++; end
      cmps++;
   endtask

   task automatic test_invalid_dims();
      int c0;
      do_reset();
      drive(1'b1, 3'd2, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(7);
      clear_log();
      drive(1'b1, 3'd0, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
      c0 = cyc;
      idle(6);
      if (done_q.size() !== 1) begin $display("FAIL inv0_done_count: got %0d want 1", done_q.size()); errs++; end
      else if (done_q[0].cyc !== c0 + 3 || done_q[0].err !== 1'b1 || done_q[0].src !== 1'b0) begin
         $display("FAIL inv0_done: got cyc+%0d err%0d src%0d want cyc+3 err1 src0",
                  done_q[0].cyc - c0, done_q[0].err, done_q[0].src);
         errs++;
      end
      cmps++;
      drive(1'b1, 3'd6, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(6);
      if (done_q.size() !== 2) begin $display("FAIL inv6_done_count: got %0d want 2", done_q.size()); errs++; end
      else if (done_q[1].err !== 1'b1) begin $display("FAIL inv6_done_err: got %0d want 1", done_q[1].err); errs++; end
      cmps++;
      if (wr_q.size() !== 0) begin $display("FAIL inv_wr_en: got %0d writes want 0", wr_q.size()); errs++; end
      cmps++;
      q_row = 3'd2; q_col = 3'd3; #1;
      if (q_count !== 3'd1) begin $display("FAIL inv_q23: got %0d want 1", q_count); errs++; end
      cmps++;
      q_row = 3'd0; q_col = 3'd4; #1;
      if (q_count !== 3'd0) begin $display("FAIL inv_q04: got %0d want 0", q_count); errs++; end
      cmps++;
      q_row = 3'd6; q_col = 3'd2; #1;
      if (q_count !== 3'd0) begin $display("FAIL inv_q62: got %0d want 0", q_count); errs++; end
      cmps++;
      clear_log();
      drive(1'b1, 3'd5, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(7);
      if (wr_q.size() !== 1 || done_q.size() !== 1) begin
         $display("FAIL max_dim_write: got %0d writes %0d dones want 1 1", wr_q.size(), done_q.size()); errs++;
      end else if (done_q[0].err !== 1'b0 || wr_q[0].idx !== 3'd0) begin
         $display("FAIL max_dim_fields: got err%0d idx%0d want err0 idx0", done_q[0].err, wr_q[0].idx); errs++;
      end
      cmps++;
      q_row = 3'd5; q_col = 3'd5; #1;
      if (q_count !== 3'd1) begin $display("FAIL max_dim_q55: got %0d want 1", q_count); errs++; end
      cmps++;
   endtask

   task automatic test_overflow();
      int c0;
      do_reset();
      drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 3'd2, 1'b0);
      c0 = cyc;
      idle(1);
      drive(1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0);
      drive(1'b1, 3'd4, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(14);
      if (ovf_rx_n !== 1 || ovf_rx_cyc !== c0 + 4) begin
         $display("FAIL ovf_rx: got n%0d at cyc+%0d want n1 at cyc+4", ovf_rx_n, ovf_rx_cyc - c0); errs++;
      end
      cmps++;
      if (ovf_cmp_n !== 0) begin $display("FAIL ovf_cmp: got %0d want 0", ovf_cmp_n); errs++; end
      cmps++;
      if (wr_q.size() !== 2) begin $display("FAIL ovf_wr_count: got %0d want 2", wr_q.size()); errs++; end
      else if ({wr_q[0].sel, wr_q[0].row, wr_q[0].col, wr_q[1].sel, wr_q[1].row, wr_q[1].col}
               !== {1'b1, 3'd1, 3'd2, 1'b0, 3'd4, 3'd5}) begin
         $display("FAIL ovf_wr_dims: got sel%0d %0dx%0d then sel%0d %0dx%0d want sel1 1x2 then sel0 4x5",
                  wr_q[0].sel, wr_q[0].row, wr_q[0].col, wr_q[1].sel, wr_q[1].row, wr_q[1].col);
         errs++;
      end
      cmps++;
      q_row = 3'd2; q_col = 3'd2; #1;
      if (q_count !== 3'd0) begin $display("FAIL ovf_q22: got %0d want 0", q_count); errs++; end
      cmps++;
   endtask

   task automatic test_grant_collision();
      int c0;
      do_reset();
      drive(1'b1, 3'd1, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0);
      c0 = cyc;
      drive(1'b1, 3'd2, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(12);
      if (ovf_rx_n !== 0) begin $display("FAIL coll_ovf: got %0d want 0", ovf_rx_n); errs++; end
      cmps++;
      if (wr_q.size() !== 2) begin $display("FAIL coll_wr_count: got %0d want 2", wr_q.size()); errs++; end
      else if ({wr_q[0].row, wr_q[0].col, wr_q[1].row, wr_q[1].col} !== {3'd1, 3'd3, 3'd2, 3'd4}
               || wr_q[1].cyc !== c0 + 7) begin
         $display("FAIL coll_wr: got %0dx%0d then %0dx%0d at cyc+%0d want 1x3 then 2x4 at cyc+7",
                  wr_q[0].row, wr_q[0].col, wr_q[1].row, wr_q[1].col, wr_q[1].cyc - c0);
         errs++;
      end
      cmps++;
   endtask

   task automatic test_clear();
      int c0;
      do_reset();
      drive(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
      c0 = cyc;
      idle(2);
      drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
      idle(6);
      if (wr_q.size() !== 1 || wr_q[0].cyc !== c0 + 3) begin
         $display("FAIL clr_wr_seen: got n%0d want one write at cyc+3", wr_q.size()); errs++;
      end
      cmps++;
      q_row = 3'd4; q_col = 3'd4; #1;
      if (q_count !== 3'd0) begin $display("FAIL clr_q44: got %0d want 0", q_count); errs++; end
      cmps++;
      clear_log();
      drive(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(7);
      if (wr_q.size() !== 1) begin $display("FAIL clr_next_count: got %0d want 1", wr_q.size()); errs++; end
      else if (wr_q[0].idx !== 3'd0) begin $display("FAIL clr_next_idx: got %0d want 0", wr_q[0].idx); errs++; end
      cmps++;
      drive(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(7);
      q_row = 3'd4; q_col = 3'd4; #1;
      if (q_count !== 3'd2) begin $display("FAIL clr_refill_q44: got %0d want 2", q_count); errs++; end
      cmps++;
      drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1);
      idle(1);
      #1;
      if (q_count !== 3'd0) begin $display("FAIL clr_idle_q44: got %0d want 0", q_count); errs++; end
      cmps++;
   endtask

   task automatic test_reset_midop();
      do_reset();
      drive(1'b1, 3'd3, 3'd2, 1'b0, 3'd0, 3'd0, 1'b0);
      idle(1);
      @(posedge clk); #1;
      if (busy !== 1'b1) begin $display("FAIL midrst_busy_before: got %0d want 1", busy); errs++; end
      cmps++;
      rst = 1'b1;
      #1;
      if ({busy, wr_en, done} !== 3'b000) begin
         $display("FAIL midrst_async: got busy%0d wr_en%0d done%0d want 000", busy, wr_en, done); errs++;
      end
      cmps++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(8);
      if (wr_q.size() !== 0 || done_q.size() !== 0) begin
         $display("FAIL midrst_lost: got %0d writes %0d dones want 0 0", wr_q.size(), done_q.size()); errs++;
      end
      cmps++;
      q_row = 3'd3; q_col = 3'd2; #1;
      if (q_count !== 3'd0) begin $display("FAIL midrst_q32: got %0d want 0", q_count); errs++; end
      cmps++;
   endtask

   initial begin
      clear_log();
      test_reset();
      test_single();
      test_slot_rotation();
      test_round_robin();
      test_invalid_dims();
      test_overflow();
      test_grant_collision();
      test_clear();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
